instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program sequencer that drives the instruction side of the lab processor. Program words are stored in a small on-chip memory, then issued one at a time on DIN with a one-cycle Run pulse. The block waits for the processor's Done before advancing. It sits between the switch/key input logic and the processor, and replaces manual SW/Run entry of instructions.

## Interface
- DEPTH, 16, number of program words.
- AW, 4, pc width; must equal log2(DEPTH).
- TIMEOUT, 8, maximum WAIT cycles allowed without Done before error.

- CLK_1HZ  in  1  block clock; all state changes on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- load_en  in  1  when IDLE, write wr_data into the next free program word.
- wr_data  in  8  program word: [1:0]=op (00 mv, 01 mvi, 10 add, 11 sub), [4:2]=X, [7:5]=Y.
- start  in  1  begin execution at address 0.
- Done  in  1  processor completion, sampled on the clock edge.
- DIN  out  8  word presented to the processor; registered.
- Run  out  1  one-cycle pulse marking a new instruction on DIN; registered.
- pc  out  AW  address of the instruction currently issued or waited on.
- len  out  AW+1  number of words loaded (0..DEPTH).
- full  out  1  len == DEPTH.
- busy  out  1  high in ISSUE and WAIT.
- err  out  1  sticky error flag (timeout, or mvi without immediate).

## Operation
- States: IDLE, ISSUE, WAIT, HALT.
- Reset (resetn=0 at an edge) sets DIN=0, Run=0, pc=0, len=0, full=0, busy=0, err=0 and enters IDLE. Memory contents are not reset.
- Reset wins over every other input. Reset during ISSUE or WAIT drops Run and busy on that edge and discards the program (len=0).
- IDLE behaviour:
  - load_en writes mem[len] and increments len.
  - Writes are ignored when full=1.
  - start with len>0 sets pc=0 and enters ISSUE.
  - start with len=0 is ignored.
  - start and load_en in the same cycle: start wins, the write is dropped.
- ISSUE behaviour:
  - Sets DIN=mem[pc] and Run=1 for this cycle only, then goes to WAIT.
  - If op(mem[pc])==01 and pc+1 >= len, the mvi has no immediate. Run is not asserted, err is set, and the state goes to HALT.
- WAIT behaviour:
  - Run=0.
  - DIN=mem[pc+1] (the immediate) if the issued op was mvi, otherwise DIN holds mem[pc].
  - Done=1 advances pc by 2 for mvi, 1 otherwise.
  - If the new pc is below len, go to ISSUE; otherwise go to IDLE with DIN=0 and pc=len.
- Timeout: a counter clears in ISSUE and increments each WAIT cycle without Done. When it reaches TIMEOUT, err is set and the state goes to HALT.
- HALT behaviour:
  - DIN=0, Run=0, busy=0.
  - load_en is ignored.
  - start clears err, sets pc=0 and enters ISSUE; the program is retained.
- Done outside WAIT (including the ISSUE cycle itself) is ignored.
- load_en outside IDLE is ignored.
- pc arithmetic is AW+1 bits wide internally, so pc+2 past DEPTH compares correctly and never wraps.

## Timing
- start sampled at edge e: Run=1 and DIN=mem[0] during cycle e+1 (ISSUE).
- Cycle e+2 is the first WAIT cycle. For mvi, DIN changes to the immediate here.
- Done sampled high at edge d during WAIT: the next instruction's Run is high in cycle d+1. Minimum issue spacing is 2 cycles (Done returned in the first WAIT cycle).
- Last instruction: Done at edge d gives busy=0, state IDLE and DIN=0 from cycle d+1.
- Timeout: with no Done, err rises at the edge that ends the TIMEOUT-th WAIT cycle.
- len and full update on the edge that samples load_en.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert resetn=0 for 1 edge in WAIT → next cycle DIN=0, Run=0, pc=0, len=0, busy=0, err=0; state IDLE.
- Plain program: load 0x08, 0x2A, 0x4B, then start; testbench returns Done 1 cycle after each Run → three Run pulses with DIN 0x08, 0x2A, 0x4B; pc steps 0→1→2→3; busy falls after the third Done; len=3.
- mvi: load 0x05, 0xA5, 0x06, then start → Run with DIN=0x05, then DIN=0xA5 held until Done; pc 0→2; next Run carries DIN=0x06.
- Timeout: load 0x08, start, never assert Done → err=1 exactly 8 WAIT cycles after Run; state HALT. Then start → err=0 and Run reissues 0x08.
- Full / start ignore: start with len=0 → no Run. Load 17 words → full=1 after the 16th, len=16, the 17th is ignored. start+load_en in the same cycle → execution begins, len unchanged.
- Missing immediate: load a lone 0x05, start → no Run pulse, err=1, state HALT; a Done pulse in HALT has no effect.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer for the lab processor: stores program words, then issues them
// one at a time on DIN with a Run pulse, advancing on the processor's Done.
module instr_sequencer #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 8
) (
   input  logic          CLK_1HZ,
   input  logic          resetn,
   input  logic          load_en,
   input  logic [7:0]    wr_data,
   input  logic          start,
   input  logic          Done,
   output logic [7:0]    DIN,
   output logic          Run,
   output logic [AW-1:0] pc,
   output logic [AW:0]   len,
   output logic          full,
   output logic          busy,
   output logic          err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

   state_t        state_q;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    din_q;
   logic          run_q;
   logic [AW:0]   pc_q;
   logic [AW:0]   len_q;
   logic          full_q;
   logic          busy_q;
   logic          err_q;
   logic          isMvi_q;
   logic [TW-1:0] cnt_q;

   logic [AW:0]   stepPc_d;
   logic [7:0]    nextWord_d;
   logic          nextBad_d;
   logic          firstBad_d;
   logic          curBad_d;
   logic [AW-1:0] immAddr_d;
   logic          wrEn_d;

   // Run is registered, so a missing mvi immediate must be spotted one edge early.
   always_comb begin
      stepPc_d   = pc_q + (isMvi_q ? (AW+1)'(2) : (AW+1)'(1));
      nextWord_d = mem[stepPc_d[AW-1:0]];
      nextBad_d  = (nextWord_d[1:0] == 2'b01) && ((stepPc_d + (AW+1)'(1)) >= len_q);
      firstBad_d = (mem[0][1:0] == 2'b01) && (len_q <= (AW+1)'(1));
      curBad_d   = (din_q[1:0] == 2'b01) && ((pc_q + (AW+1)'(1)) >= len_q);
      immAddr_d  = pc_q[AW-1:0] + AW'(1);
      wrEn_d     = resetn && (state_q == IDLE) && load_en && !start && !full_q;
   end

   always_ff @(posedge CLK_1HZ) begin
      if (wrEn_d) begin
         mem[len_q[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge CLK_1HZ) begin
      if (!resetn) begin
         state_q <= IDLE;
         din_q   <= 8'h00;
         run_q   <= 1'b0;
         pc_q    <= '0;
         len_q   <= '0;
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         isMvi_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         run_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && (len_q != '0)) begin
                  pc_q    <= '0;
                  din_q   <= mem[0];
                  run_q   <= !firstBad_d;
                  busy_q  <= 1'b1;
                  state_q <= ISSUE;
               end else if (load_en && !full_q) begin
                  len_q  <= len_q + (AW+1)'(1);
                  full_q <= ((len_q + (AW+1)'(1)) == (AW+1)'(DEPTH));
               end
            end
            ISSUE: begin
               cnt_q <= '0;
               if (curBad_d) begin
                  err_q   <= 1'b1;
                  din_q   <= 8'h00;
                  busy_q  <= 1'b0;
                  state_q <= HALT;
               end else begin
                  isMvi_q <= (din_q[1:0] == 2'b01);
                  if (din_q[1:0] == 2'b01) begin
                     din_q <= mem[immAddr_d];
                  end
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (Done) begin
                  if (stepPc_d < len_q) begin
                     pc_q    <= stepPc_d;
                     din_q   <= nextWord_d;
                     run_q   <= !nextBad_d;
                     state_q <= ISSUE;
                  end else begin
                     pc_q    <= len_q;
                     din_q   <= 8'h00;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else if ((cnt_q + TW'(1)) == TW'(TIMEOUT)) begin
                  err_q   <= 1'b1;
                  din_q   <= 8'h00;
                  busy_q  <= 1'b0;
                  state_q <= HALT;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            HALT: begin
               if (start) begin
                  err_q   <= 1'b0;
                  pc_q    <= '0;
                  din_q   <= mem[0];
                  run_q   <= !firstBad_d;
                  busy_q  <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DIN  = din_q;
   assign Run  = run_q;
   assign pc   = pc_q[AW-1:0];
   assign len  = len_q;
   assign full = full_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected Run transactions are queued by the
// stimulus and checked by an independent monitor whenever Run is seen.
module tb_instr_sequencer;

   logic       CLK_1HZ = 1'b0;
   logic       resetn;
   logic       load_en;
   logic [7:0] wr_data;
   logic       start;
   logic       Done;
   logic [7:0] DIN;
   logic       Run;
   logic [3:0] pc;
   logic [4:0] len;
   logic       full;
   logic       busy;
   logic       err;

   typedef struct {
      logic [7:0] din;
      logic [3:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic autoDone = 1'b0;
   logic prevRun = 1'b0;

   instr_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(8)) dut (
      .CLK_1HZ(CLK_1HZ),
      .resetn (resetn),
      .load_en(load_en),
      .wr_data(wr_data),
      .start  (start),
      .Done   (Done),
      .DIN    (DIN),
      .Run    (Run),
      .pc     (pc),
      .len    (len),
      .full   (full),
      .busy   (busy),
      .err    (err)
   );

   initial forever #5 CLK_1HZ = ~CLK_1HZ;

   task automatic cycle();
      @(posedge CLK_1HZ);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic st, input logic [7:0] w);
      load_en = ld;
      start   = st;
      wr_data = w;
      cycle();
      load_en = 1'b0;
      start   = 1'b0;
   endtask

   task automatic pushExp(input logic [7:0] d, input logic [3:0] p);
      exp_t e;
      e.din = d;
      e.pc  = p;
      sb.push_back(e);
   endtask

   task automatic doReset();
      resetn = 1'b0;
      cycle();
      resetn = 1'b1;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         cycle();
         n++;
      end
      checkOutput("idle_wait_busy", int'(busy), 0);
   endtask

   // Monitor: every Run pulse must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge CLK_1HZ);
         if (Run === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_run: got DIN 0x%0h pc %0d, expected no Run", DIN, pc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("run_din", int'(DIN), int'(e.din));
               checkOutput("run_pc", int'(pc), int'(e.pc));
            end
         end
      end
   end

   // Processor model: answers Done in the cycle right after each Run when enabled.
   initial begin
      forever begin
         @(posedge CLK_1HZ);
         #1;
         if (autoDone) Done = prevRun;
         prevRun = Run;
      end
   end

   initial begin
      resetn  = 1'b0;
      load_en = 1'b0;
      start   = 1'b0;
      Done    = 1'b0;
      wr_data = 8'h00;
      cycle();
      cycle();
      resetn = 1'b1;
      checkOutput("rst_din", int'(DIN), 0);
      checkOutput("rst_run", int'(Run), 0);
      checkOutput("rst_pc", int'(pc), 0);
      checkOutput("rst_len", int'(len), 0);
      checkOutput("rst_full", int'(full), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_err", int'(err), 0);

      $display("[TB] start with empty program");
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("empty_start_busy", int'(busy), 0);
      cycle();
      checkOutput("empty_start_run", int'(Run), 0);

      $display("[TB] plain program");
      applyStimulus(1'b1, 1'b0, 8'h08);
      applyStimulus(1'b1, 1'b0, 8'h2A);
      applyStimulus(1'b1, 1'b0, 8'h4B);
      checkOutput("plain_len", int'(len), 3);
      pushExp(8'h08, 4'd0);
      pushExp(8'h2A, 4'd1);
      pushExp(8'h4B, 4'd2);
      autoDone = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'hFF);
      checkOutput("plain_start_run", int'(Run), 1);
      checkOutput("plain_start_busy", int'(busy), 1);
      checkOutput("start_load_len", int'(len), 3);
      waitIdle(40);
      autoDone = 1'b0;
      Done     = 1'b0;
      checkOutput("plain_end_pc", int'(pc), 3);
      checkOutput("plain_end_din", int'(DIN), 0);
      checkOutput("plain_end_len", int'(len), 3);

      $display("[TB] mvi with immediate");
      doReset();
      applyStimulus(1'b1, 1'b0, 8'h05);
      applyStimulus(1'b1, 1'b0, 8'hA5);
      applyStimulus(1'b1, 1'b0, 8'h06);
      pushExp(8'h05, 4'd0);
      pushExp(8'h06, 4'd2);
      applyStimulus(1'b0, 1'b1, 8'h00);
      cycle();
      checkOutput("mvi_wait1_din", int'(DIN), 8'hA5);
      checkOutput("mvi_wait1_run", int'(Run), 0);
      checkOutput("mvi_wait1_pc", int'(pc), 0);
      cycle();
      checkOutput("mvi_wait2_din", int'(DIN), 8'hA5);
      Done = 1'b1;
      cycle();
      Done = 1'b0;
      checkOutput("mvi_next_pc", int'(pc), 2);
      cycle();
      Done = 1'b1;
      cycle();
      Done = 1'b0;
      checkOutput("mvi_end_busy", int'(busy), 0);
      checkOutput("mvi_end_pc", int'(pc), 3);
      checkOutput("mvi_end_din", int'(DIN), 0);

      $display("[TB] timeout");
      doReset();
      applyStimulus(1'b1, 1'b0, 8'h08);
      pushExp(8'h08, 4'd0);
      applyStimulus(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 8; i++) cycle();
      checkOutput("to_before_err", int'(err), 0);
      checkOutput("to_before_busy", int'(busy), 1);
      cycle();
      checkOutput("to_err", int'(err), 1);
      checkOutput("to_busy", int'(busy), 0);
      checkOutput("to_din", int'(DIN), 0);
      pushExp(8'h08, 4'd0);
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("to_restart_err", int'(err), 0);
      checkOutput("to_restart_run", int'(Run), 1);
      cycle();
      cycle();
      checkOutput("wait_busy", int'(busy), 1);
      doReset();
      checkOutput("wrst_din", int'(DIN), 0);
      checkOutput("wrst_run", int'(Run), 0);
      checkOutput("wrst_busy", int'(busy), 0);
      checkOutput("wrst_len", int'(len), 0);
      checkOutput("wrst_pc", int'(pc), 0);
      checkOutput("wrst_err", int'(err), 0);

      $display("[TB] full program");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i * 4));
      end
      checkOutput("full_flag", int'(full), 1);
      checkOutput("full_len", int'(len), 16);
      applyStimulus(1'b1, 1'b0, 8'hFC);
      checkOutput("full_len_17th", int'(len), 16);
      for (int i = 0; i < 16; i++) begin
         pushExp(8'(i * 4), 4'(i));
      end
      autoDone = 1'b1;
      applyStimulus(1'b0, 1'b1, 8'h00);
      waitIdle(120);
      autoDone = 1'b0;
      Done     = 1'b0;
      checkOutput("full_end_din", int'(DIN), 0);
      checkOutput("full_end_len", int'(len), 16);

      $display("[TB] missing immediate");
      doReset();
      applyStimulus(1'b1, 1'b0, 8'h05);
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("noimm_run", int'(Run), 0);
      cycle();
      checkOutput("noimm_err", int'(err), 1);
      checkOutput("noimm_busy", int'(busy), 0);
      Done = 1'b1;
      cycle();
      Done = 1'b0;
      cycle();
      checkOutput("halt_done_err", int'(err), 1);
      checkOutput("halt_done_busy", int'(busy), 0);
      checkOutput("halt_done_pc", int'(pc), 0);
      applyStimulus(1'b1, 1'b0, 8'h77);
      checkOutput("halt_load_len", int'(len), 1);

      cycle();
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
